// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: packet types, PID nibbles, controller states and default SYNC value for the USB receiver
package usb_rx_pkg;
  typedef enum logic [2:0] {
    PKT_NONE, PKT_OUT, PKT_IN, PKT_DATA0, PKT_DATA1, PKT_ACK, PKT_NAK, PKT_STALL
  } rx_packet_t;
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC_WAIT, S_PID_WAIT, S_DATA_WAIT, S_EOP_WAIT, S_DONE, S_ERR, S_ERR_WAIT
  } rx_state_t;
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
endpackage

// File: rtl/usb_pid_decode.sv
// usb_pid_decode: PID byte to packet type; RX_PID_CHECK_EN adds the upper-nibble complement check
module usb_pid_decode
  import usb_rx_pkg::*;
(
  input  logic [7:0] pid,
  output logic       valid,
  output logic [2:0] pkt
);
`ifdef RX_PID_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  rx_packet_t p;
  always_comb begin
    p = pid[3:0] == PID_OUT   ? PKT_OUT   :
        pid[3:0] == PID_IN    ? PKT_IN    :
        pid[3:0] == PID_DATA0 ? PKT_DATA0 :
        pid[3:0] == PID_DATA1 ? PKT_DATA1 :
        pid[3:0] == PID_ACK   ? PKT_ACK   :
        pid[3:0] == PID_NAK   ? PKT_NAK   :
        pid[3:0] == PID_STALL ? PKT_STALL : PKT_NONE;
    valid = p != PKT_NONE && (!CHECK || pid[7:4] == ~pid[3:0]);
    pkt = valid ? p : PKT_NONE;
  end
endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: USB receive packet sequencer (SYNC, PID, payload, EOP); PID check via RX_PID_CHECK_EN
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         MAX_PAYLOAD = 64,
  parameter int         CNT_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             eop,
  input  logic             shift_enable,
  input  logic             byte_received,
  input  logic [7:0]       rx_byte,
  input  logic             buffer_full,
  output logic             rx_transfer_active,
  output logic [2:0]       rx_packet,
  output logic             rx_data_ready,
  output logic             rx_error,
  output logic             store_rx_data,
  output logic [CNT_W-1:0] rx_byte_count
);
  rx_state_t state_q, state_d;
  logic active_q, active_d, ready_q, ready_d, err_q, err_d;
  logic [2:0] pkt_q, pkt_d, pid_pkt;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic eop_v, pid_ok;
  usb_pid_decode u_pid (.pid(rx_byte), .valid(pid_ok), .pkt(pid_pkt));
  always_comb begin
    eop_v = eop && shift_enable;
    store_rx_data = state_q == S_DATA_WAIT && byte_received && !buffer_full
                    && cnt_q < CNT_W'(MAX_PAYLOAD);
    cnt_inc = cnt_q + CNT_W'(store_rx_data);
    state_d = state_q;
    pkt_d = pkt_q;
    cnt_d = cnt_inc;
    case (state_q)
      S_IDLE: if (d_edge) begin
        state_d = S_SYNC_WAIT;
        pkt_d = PKT_NONE;
        cnt_d = '0;
      end
      S_SYNC_WAIT: if (byte_received) state_d = rx_byte == SYNC_BYTE ? S_PID_WAIT : S_ERR;
        else if (eop_v) state_d = S_ERR;
      S_PID_WAIT: if (byte_received) begin
        state_d = !pid_ok ? S_ERR :
                  (pid_pkt == PKT_DATA0 || pid_pkt == PKT_DATA1) ? S_DATA_WAIT : S_EOP_WAIT;
        pkt_d = pid_pkt;
      end else if (eop_v) state_d = S_ERR;
      S_DATA_WAIT: if (byte_received && !store_rx_data) state_d = S_ERR;
        else if (eop_v) state_d = cnt_inc >= CNT_W'(2) ? S_DONE : S_ERR;
      S_EOP_WAIT: if (eop_v) state_d = S_DONE;
        else if (byte_received) state_d = S_ERR;
      S_DONE: state_d = S_IDLE;
      S_ERR: state_d = eop_v ? S_IDLE : S_ERR_WAIT;
      default: if (eop_v) state_d = S_IDLE;
    endcase
    err_d = state_d == S_ERR || (err_q && !(state_q == S_SYNC_WAIT && state_d == S_PID_WAIT));
    active_d = state_d != S_IDLE;
    ready_d = state_d == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      active_q <= 1'b0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      pkt_q <= PKT_NONE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      active_q <= active_d;
      ready_q <= ready_d;
      err_q <= err_d;
      pkt_q <= pkt_d;
      cnt_q <= cnt_d;
    end
  end
  assign rx_transfer_active = active_q;
  assign rx_packet = pkt_q;
  assign rx_data_ready = ready_q;
  assign rx_error = err_q;
  assign rx_byte_count = cnt_q;
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: table vectors, corner sequences and random packets against a packet-level model
module tb_usb_rx_ctrl;
  logic clk = 1'b0, rst = 1'b1, d_edge = 1'b0, eop = 1'b0, shift_enable = 1'b0;
  logic byte_received = 1'b0, buffer_full = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic rx_transfer_active, rx_data_ready, rx_error, store_rx_data;
  logic [2:0] rx_packet;
  logic [6:0] rx_byte_count;
  int total = 0, bad = 0, n_st = 0, n_rdy = 0;
  usb_rx_ctrl dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
    .byte_received(byte_received), .rx_byte(rx_byte), .buffer_full(buffer_full),
    .rx_transfer_active(rx_transfer_active), .rx_packet(rx_packet),
    .rx_data_ready(rx_data_ready), .rx_error(rx_error),
    .store_rx_data(store_rx_data), .rx_byte_count(rx_byte_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (store_rx_data) n_st++;
    if (rx_data_ready) n_rdy++;
  end
  typedef struct {
    logic [7:0] s, p;
    int n, bf;
    bit el;
    int st, rdy, err, pkt, cnt;
  } vec_t;
  vec_t tv[15];
  int pid_map[16] = '{0, 1, 5, 3, 0, 0, 0, 0, 0, 2, 6, 4, 0, 0, 7, 0};
  int codes[7] = '{1, 9, 3, 11, 2, 10, 14};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit bf, input bit e);
    rx_byte = b;
    byte_received = 1'b1;
    buffer_full = bf;
    eop = e;
    shift_enable = e;
    tick();
    byte_received = 1'b0;
    buffer_full = 1'b0;
    eop = 1'b0;
    shift_enable = 1'b0;
    repeat (2) tick();
  endtask
  task automatic pulse_eop();
    eop = 1'b1;
    shift_enable = 1'b1;
    tick();
    eop = 1'b0;
    shift_enable = 1'b0;
    repeat (2) tick();
  endtask
  task automatic drive_pkt(input logic [7:0] s, input logic [7:0] p, input int n, input int bf, input bit el);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    tick();
    send(s, 1'b0, 1'b0);
    send(p, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) send(8'($urandom), i == bf, el && i == n - 1);
    pulse_eop();
    pulse_eop();
    repeat (2) tick();
  endtask
  function automatic void model(input logic [7:0] s, input logic [7:0] p, input int n, input int bf,
                                output int st, output int rdy, output int err, output int pkt, output int cnt);
    int lim;
    st = 0; rdy = 0; err = 1; pkt = 0; cnt = 0;
    if (s != 8'h80) return;
    pkt = pid_map[p[3:0]];
`ifdef RX_PID_CHECK_EN
    if (p[7:4] != ~p[3:0]) pkt = 0;
`endif
    if (pkt == 0) return;
    if (pkt != 3 && pkt != 4) begin
      err = n > 0 ? 1 : 0;
      rdy = 1 - err;
      return;
    end
    lim = n;
    if (bf >= 0 && bf < lim) lim = bf;
    if (lim > 64) lim = 64;
    st = lim;
    cnt = lim;
    err = (lim < n || n < 2) ? 1 : 0;
    rdy = 1 - err;
  endfunction
  task automatic run(input string nm, input logic [7:0] s, input logic [7:0] p, input int n, input int bf,
                     input bit el, input int st, input int rdy, input int err, input int pkt, input int cnt);
    int st0, rdy0;
    st0 = n_st;
    rdy0 = n_rdy;
    drive_pkt(s, p, n, bf, el);
    chk({nm, "_store"}, n_st - st0, st);
    chk({nm, "_ready"}, n_rdy - rdy0, rdy);
    chk({nm, "_error"}, int'(rx_error), err);
    chk({nm, "_packet"}, int'(rx_packet), pkt);
    chk({nm, "_count"}, int'(rx_byte_count), cnt);
    chk({nm, "_active"}, int'(rx_transfer_active), 0);
  endtask
  initial begin
    int st, rdy, err, pkt, cnt, n, bf, r;
    logic [7:0] s, p;
    logic [3:0] lo;
    bit el, is_data;
    tv[0]  = '{8'h80, 8'hE1, 0, -1, 1'b0, 0, 1, 0, 1, 0};
    tv[1]  = '{8'h80, 8'hC3, 4, -1, 1'b0, 4, 1, 0, 3, 4};
    tv[2]  = '{8'h81, 8'hE1, 0, -1, 1'b0, 0, 0, 1, 0, 0};
    tv[3]  = '{8'h80, 8'hD2, 0, -1, 1'b0, 0, 1, 0, 5, 0};
    tv[4]  = '{8'h80, 8'h4B, 65, -1, 1'b0, 64, 0, 1, 4, 64};
    tv[5]  = '{8'h80, 8'hC3, 5, 2, 1'b0, 2, 0, 1, 3, 2};
    tv[6]  = '{8'h80, 8'hC3, 1, -1, 1'b0, 1, 0, 1, 3, 1};
    tv[7]  = '{8'h80, 8'hC3, 2, -1, 1'b1, 2, 1, 0, 3, 2};
`ifdef RX_PID_CHECK_EN
    tv[8]  = '{8'h80, 8'h01, 0, -1, 1'b0, 0, 0, 1, 0, 0};
`else
    tv[8]  = '{8'h80, 8'h01, 0, -1, 1'b0, 0, 1, 0, 1, 0};
`endif
    tv[9]  = '{8'h80, 8'h69, 1, -1, 1'b0, 0, 0, 1, 2, 0};
    tv[10] = '{8'h80, 8'hF0, 0, -1, 1'b0, 0, 0, 1, 0, 0};
    tv[11] = '{8'h80, 8'h1E, 0, -1, 1'b0, 0, 1, 0, 7, 0};
    tv[12] = '{8'h80, 8'h5A, 0, -1, 1'b0, 0, 1, 0, 6, 0};
    tv[13] = '{8'h80, 8'h4B, 64, -1, 1'b0, 64, 1, 0, 4, 64};
    tv[14] = '{8'h80, 8'hC3, 0, -1, 1'b0, 0, 0, 1, 3, 0};
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_active", int'(rx_transfer_active), 0);
    chk("rst_packet", int'(rx_packet), 0);
    chk("rst_ready", int'(rx_data_ready), 0);
    chk("rst_error", int'(rx_error), 0);
    chk("rst_store", int'(store_rx_data), 0);
    chk("rst_count", int'(rx_byte_count), 0);
    tick();
    for (int i = 0; i < 15; i++)
      run($sformatf("vec%0d", i), tv[i].s, tv[i].p, tv[i].n, tv[i].bf, tv[i].el,
          tv[i].st, tv[i].rdy, tv[i].err, tv[i].pkt, tv[i].cnt);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    tick();
    send(8'h81, 1'b0, 1'b0);
    chk("badsync_err", int'(rx_error), 1);
    chk("badsync_hold", int'(rx_transfer_active), 1);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    tick();
    chk("eop_unqualified", int'(rx_transfer_active), 1);
    pulse_eop();
    chk("badsync_idle", int'(rx_transfer_active), 0);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    tick();
    send(8'h80, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    chk("mid_count", int'(rx_byte_count), 2);
    chk("mid_active", int'(rx_transfer_active), 1);
    chk("mid_error", int'(rx_error), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    byte_received = 1'b1;
    #1;
    chk("mrst_active", int'(rx_transfer_active), 0);
    chk("mrst_packet", int'(rx_packet), 0);
    chk("mrst_count", int'(rx_byte_count), 0);
    chk("mrst_store", int'(store_rx_data), 0);
    chk("mrst_ready", int'(rx_data_ready), 0);
    byte_received = 1'b0;
    tick();
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    tick();
    send(8'h81, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("erst_error", int'(rx_error), 0);
    chk("erst_active", int'(rx_transfer_active), 0);
    tick();
    for (int k = 0; k < 40; k++) begin
      s = $urandom_range(0, 9) == 0 ? 8'($urandom) : 8'h80;
      r = int'($urandom_range(0, 3));
      lo = 4'(codes[$urandom_range(0, 6)]);
      p = r < 2 ? {~lo, lo} : r == 2 ? {4'($urandom), lo} : 8'($urandom);
      is_data = p[3:0] == 4'h3 || p[3:0] == 4'hB;
      if (is_data) n = $urandom_range(0, 4) == 0 ? int'($urandom_range(60, 66)) : int'($urandom_range(0, 8));
      else n = $urandom_range(0, 3) == 0 ? 1 : 0;
      bf = (is_data && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, n)) : -1;
      el = is_data && n > 0 && $urandom_range(0, 1) == 1;
      model(s, p, n, bf, st, rdy, err, pkt, cnt);
      run($sformatf("rnd%0d", k), s, p, n, bf, el, st, rdy, err, pkt, cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
Packet-level sequencer for the USB receiver. It consumes bit/byte strobes from the rx timing block (d_edge, shift_enable, byte_received) and the assembled byte from the rx shift register, then walks SYNC -> PID -> payload -> EOP. It writes payload bytes into the rx buffer, reports the packet type, and flags protocol errors. It sits between the rx timer/shift register and the rx FIFO/protocol layer.

Parameters:
SYNC_BYTE, 8'h80, value of rx_byte required for a valid SYNC field
MAX_PAYLOAD, 64, maximum payload bytes (data + CRC16) accepted per DATA packet
CNT_W, 7, width of rx_byte_count; must hold MAX_PAYLOAD

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
d_edge  in  1  single-cycle pulse on a bus transition
eop  in  1  SE0/EOP detected at a sample point
shift_enable  in  1  bit sample strobe from rx timer
byte_received  in  1  single-cycle pulse: 8th bit shifted in; rx_byte is valid this cycle
rx_byte  in  8  assembled byte, LSB received first
buffer_full  in  1  rx buffer cannot accept a write
rx_transfer_active  out  1  high from start-of-packet until DONE/ERR exit
rx_packet  out  3  0 NONE, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL
rx_data_ready  out  1  one-cycle pulse when a packet completes cleanly
rx_error  out  1  sticky error flag
store_rx_data  out  1  one-cycle buffer write strobe for rx_byte
rx_byte_count  out  CNT_W  payload bytes stored in the current packet

Behaviour:
- Reset (rst=1 on a clk edge): state IDLE. All outputs 0, rx_packet=NONE. Reset mid-packet aborts immediately; no strobes are issued in the cycle after reset.
- States: IDLE, SYNC_WAIT, PID_WAIT, DATA_WAIT, EOP_WAIT, DONE, ERR, ERR_WAIT.
- IDLE: d_edge -> SYNC_WAIT. Set rx_transfer_active=1, rx_byte_count=0, rx_packet=NONE.
- SYNC_WAIT: byte_received with rx_byte==SYNC_BYTE -> PID_WAIT and clear rx_error. Mismatch -> ERR. eop -> ERR.
- PID_WAIT: on byte_received, decode rx_byte[3:0]: OUT 4'b0001, IN 4'b1001, DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010, STALL 4'b1110.
  - DATA0/DATA1 -> DATA_WAIT.
  - Any other valid PID -> EOP_WAIT.
  - Undefined PID -> ERR, rx_packet=NONE.
  - rx_packet is registered in the cycle after byte_received.
  - eop -> ERR.
- DATA_WAIT:
  - byte_received && !buffer_full && count<MAX_PAYLOAD: store_rx_data=1 (combinational, same cycle as byte_received); count increments next cycle.
  - byte_received && (buffer_full || count==MAX_PAYLOAD): no store, -> ERR.
  - eop: count>=2 -> DONE; count<2 (no CRC16) -> ERR.
  - byte_received and eop in the same cycle: store the byte first (same rules), then evaluate eop using count+1.
- EOP_WAIT: eop -> DONE. byte_received before eop -> ERR (trailing byte on a token/handshake packet).
- DONE (1 cycle): rx_data_ready=1, rx_transfer_active=0 next cycle, -> IDLE. rx_packet and rx_byte_count hold until the next SYNC_WAIT entry.
- ERR (1 cycle): set rx_error=1 (sticky). If eop is already high -> IDLE, else -> ERR_WAIT.
- ERR_WAIT: ignore all strobes; eop -> IDLE. rx_transfer_active stays 1 until IDLE is entered.
- shift_enable is used only to qualify eop: eop is acted on only when shift_enable=1 in the same cycle.
- rx_byte_count saturates at MAX_PAYLOAD and never wraps.

Optional Feature:
RX_PID_CHECK_EN
- Defined: PID_WAIT also requires rx_byte[7:4]==~rx_byte[3:0]. Failure -> ERR.
- Undefined: upper nibble ignored; only rx_byte[3:0] is decoded.

Decomposition:
- Package usb_rx_pkg holds:
  - rx_packet_t enum (3-bit encoding above)
  - PID nibble constants
  - the controller state enum
  - default SYNC_BYTE
- One sub-module, usb_pid_decode: combinational rx_byte -> {valid, rx_packet_t}, with the RX_PID_CHECK_EN check inside it.
- The byte counter stays inline.

Test Plan:
- Token: edge, SYNC 8'h80, PID 8'hE1 (OUT), eop+shift_enable -> rx_packet=1, rx_data_ready pulse, rx_error=0, count=0.
- Data: SYNC, PID 8'hC3 (DATA0), 4 bytes, eop -> 4 store_rx_data pulses, count=4, rx_packet=3, rx_data_ready=1.
- Bad SYNC: SYNC byte 8'h81 -> rx_error=1, no store, rx_transfer_active held until eop, then IDLE; a following good packet clears rx_error.
- Overflow: DATA1 with MAX_PAYLOAD+1 bytes -> exactly 64 stores, rx_error=1, no rx_data_ready. Also buffer_full asserted on byte 3 -> ERR, 2 stores.
- Short data: DATA0 with 1 byte, then eop -> rx_error=1. Also byte_received and eop same cycle at count=1 -> store, count=2, DONE.
- Reset mid-DATA_WAIT after 2 bytes -> next cycle all outputs 0, IDLE. With RX_PID_CHECK_EN, PID 8'h01 -> ERR; without it, PID 8'h01 -> accepted as OUT.
